// File: rtl/limn2600_mem_sched_rr.sv
`default_nettype none
// ============================================================================
// Module   : limn2600_mem_sched_rr
// Purpose  : Round-robin multi-client memory scheduler. Requests from all
//            clients share one in-order command FIFO that drives a single
//            word-wide RAM port. Sub-word stores use read-modify-write, and
//            sub-word loads are extracted and zero-extended before return.
// Revision : 1.0 - initial release
// ============================================================================
module limn2600_mem_sched_rr #(
  parameter int NUM_CLIENTS = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  input  logic [NUM_CLIENTS-1:0]        req_write,
  input  logic [2*NUM_CLIENTS-1:0]      req_size,
  input  logic [ADDR_W*NUM_CLIENTS-1:0] req_addr,
  input  logic [DATA_W*NUM_CLIENTS-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_data_out,
  input  logic [DATA_W-1:0]             ram_data_in,
  output logic                          ram_we,
  output logic                          ram_ce,
  input  logic                          ram_rdy,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int CID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CID_W:0]   NUM_CL   = (CID_W+1)'(NUM_CLIENTS);
  localparam logic [CID_W-1:0] LAST_CL  = CID_W'(NUM_CLIENTS - 1);
  localparam logic [CNT_W-1:0] DEPTH_CT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CID_W-1:0] rr_ptr;
  logic [CID_W-1:0] grant_id;
  logic             grant_any;
  logic [CID_W:0]   cand;
  logic             full;
  logic             push;
  logic             pop;

  logic [CID_W-1:0]  fifo_cid   [QUEUE_DEPTH];
  logic              fifo_we    [QUEUE_DEPTH];
  logic [1:0]        fifo_size  [QUEUE_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [QUEUE_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [CID_W-1:0]  cmd_cid;
  logic [1:0]        cmd_size;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] wr_data;

  logic [4:0]        shamt;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] extracted;

  assign full = (count == DEPTH_CT);
  assign push = grant_any && !full;
  assign pop  = (state == S_IDLE) && (count != '0);

  // Pick the first requesting client at or after the round-robin pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = {1'b0, rr_ptr} + (CID_W+1)'(k);
      if (cand >= NUM_CL) cand = cand - NUM_CL;
      if (!grant_any && req_valid[cand[CID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[CID_W-1:0];
      end
    end
  end

  // One-hot ready on the granted client, suppressed while the FIFO is full.
  always_comb begin
    req_ready = '0;
    if (push) req_ready[grant_id] = 1'b1;
  end

  // Round-robin pointer and FIFO pointers/occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        rr_ptr <= (grant_id == LAST_CL) ? '0 : grant_id + CID_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cid[wr_ptr]   <= grant_id;
      fifo_we[wr_ptr]    <= req_write[grant_id];
      fifo_size[wr_ptr]  <= req_size[2*grant_id +: 2];
      fifo_addr[wr_ptr]  <= req_addr[ADDR_W*grant_id +: ADDR_W];
      fifo_wdata[wr_ptr] <= req_wdata[DATA_W*grant_id +: DATA_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: dispatch from the FIFO head, advance on RAM completion.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pop) begin
          if (!fifo_we[rd_ptr])         state_nxt = S_READ;
          else if (fifo_size[rd_ptr][1]) state_nxt = S_WRITE;
          else                           state_nxt = S_RMW_RD;
        end
      end
      S_READ:   if (ram_rdy) state_nxt = S_IDLE;
      S_RMW_RD: if (ram_rdy) state_nxt = S_RMW_WR;
      S_RMW_WR: if (ram_rdy) state_nxt = S_IDLE;
      S_WRITE:  if (ram_rdy) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Lane position and width of the active command (little-endian).
  always_comb begin
    case (cmd_size)
      2'b00: begin
        shamt     = {cmd_addr[1:0], 3'b000};
        lane_mask = 32'h0000_00FF;
      end
      2'b01: begin
        shamt     = {cmd_addr[1], 4'b0000};
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merged    = (ram_data_in & ~(lane_mask << shamt)) | ((cmd_wdata & lane_mask) << shamt);
    extracted = (ram_data_in >> shamt) & lane_mask;
  end

  // Command register, write-data register and load response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cid    <= '0;
      cmd_size   <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      wr_data    <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      if (pop) begin
        cmd_cid   <= fifo_cid[rd_ptr];
        cmd_size  <= fifo_size[rd_ptr];
        cmd_addr  <= fifo_addr[rd_ptr];
        cmd_wdata <= fifo_wdata[rd_ptr];
        wr_data   <= fifo_wdata[rd_ptr];
      end
      if (state == S_RMW_RD && ram_rdy) wr_data <= merged;
      if (state == S_READ && ram_rdy) begin
        resp_valid[cmd_cid] <= 1'b1;
        resp_rdata          <= extracted;
      end
    end
  end

  assign ram_ce       = (state != S_IDLE);
  assign ram_we       = (state == S_WRITE) || (state == S_RMW_WR);
  assign ram_addr     = {cmd_addr[ADDR_W-1:2], 2'b00};
  assign ram_data_out = wr_data;
  assign queue_count  = count;

endmodule
`default_nettype wire

// File: tb/tb_limn2600_mem_sched_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_limn2600_mem_sched_rr
// Purpose  : Self-checking bench for limn2600_mem_sched_rr: directed scenarios
//            followed by randomized multi-client traffic against a word-level
//            memory reference model and per-client response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_limn2600_mem_sched_rr;

  localparam int N  = 2;
  localparam int QD = 8;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_write;
  logic [2*N-1:0]  req_size;
  logic [AW*N-1:0] req_addr;
  logic [32*N-1:0] req_wdata;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_rdata;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_data_out, ram_data_in;
  logic            ram_we, ram_ce, ram_rdy;
  logic [3:0]      queue_count;

  limn2600_mem_sched_rr #(.NUM_CLIENTS(N), .QUEUE_DEPTH(QD), .ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .ram_we(ram_we), .ram_ce(ram_ce), .ram_rdy(ram_rdy),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Count a comparison and report a mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bench state: RAM model, reference memory, response scoreboard, bookkeeping.
  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  logic [35:0] expq [$];
  int          grants [$];
  logic [N-1:0] acc;
  int          rr_model   = 0;
  int          lat        = 1;
  bit          stall      = 0;
  bit          rand_en    = 0;
  int          writes_seen = 0;
  int          resp_cnt   = 0;
  int          ce_cycles  = 0;
  logic [31:0] last_waddr, last_wdata, last_resp;

  function automatic logic [31:0] init_word(int unsigned wa);
    if (wa == 32'h80) return 32'h1122_3344;
    if (wa == 32'hC0) return 32'h0000_0000;
    return (wa * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] rd_mem(int unsigned wa);
    return mem.exists(wa) ? mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] rd_ref(int unsigned wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  // Apply an accepted request to the reference memory in acceptance order.
  task automatic apply_model(input int i);
    logic [31:0] a, d, cur, e;
    logic [1:0]  s;
    int unsigned wa;
    int          bl, hl;
    a  = req_addr[i*AW +: AW];
    d  = req_wdata[i*32 +: 32];
    s  = req_size[2*i +: 2];
    wa = a >> 2;
    bl = int'(a[1:0]);
    hl = int'(a[1]);
    cur = rd_ref(wa);
    e   = 32'h0;
    case (s)
      2'b00: if (req_write[i]) cur[8*bl +: 8] = d[7:0];   else e[7:0]  = cur[8*bl +: 8];
      2'b01: if (req_write[i]) cur[16*hl +: 16] = d[15:0]; else e[15:0] = cur[16*hl +: 16];
      default: if (req_write[i]) cur = d; else e = cur;
    endcase
    if (req_write[i]) ref_mem[wa] = cur;
    else expq.push_back({4'(i), e});
  endtask

  // Observe responses and grants on the falling edge.
  task automatic monitor();
    int idx, eg, c;
    check("resp_onehot", 64'($onehot0(resp_valid)), 64'd1);
    for (int i = 0; i < N; i++) begin
      if (resp_valid[i]) begin
        resp_cnt++;
        last_resp = resp_rdata;
        idx = -1;
        for (int j = 0; j < expq.size(); j++) begin
          if (expq[j][35:32] == 4'(i)) begin idx = j; break; end
        end
        if (idx < 0) check("resp_unexpected", 64'(i), 64'hFF);
        else begin
          check("resp_data", resp_rdata, expq[idx][31:0]);
          expq.delete(idx);
        end
      end
    end
    if (req_ready != '0) begin
      eg = -1;
      for (int k = 0; k < N; k++) begin
        c = (rr_model + k) % N;
        if (eg < 0 && req_valid[c]) eg = c;
      end
      check("grant", req_ready, (eg >= 0) ? 64'(1) << eg : 64'd0);
    end
    acc = req_valid & req_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        grants.push_back(i);
        rr_model = (i + 1) % N;
        apply_model(i);
      end
    end
    if (ram_ce) ce_cycles++;
  endtask

  // RAM model: random or fixed completion latency, optional stall.
  task automatic responder();
    int unsigned wa;
    if (rst || !ram_ce) begin
      ram_rdy     = (rand_en && !rst) ? ($urandom_range(0, 3) == 0) : 1'b0;
      ram_data_in = $urandom;
      lat         = rand_en ? int'($urandom_range(0, 3)) : 1;
    end else begin
      check("ram_addr_align", 64'(ram_addr[1:0]), 64'd0);
      if (stall) ram_rdy = 1'b0;
      else if (lat == 0) begin
        ram_rdy = 1'b1;
        wa = ram_addr >> 2;
        if (ram_we) begin
          mem[wa] = ram_data_out;
          last_waddr = ram_addr;
          last_wdata = ram_data_out;
          writes_seen++;
        end else ram_data_in = rd_mem(wa);
        lat = rand_en ? int'($urandom_range(0, 3)) : 1;
      end else begin
        ram_rdy = 1'b0;
        lat--;
      end
    end
  endtask

  // One clock: observe and respond on the falling edge, return #1 after rise.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      expq.delete();
      rr_model = 0;
      acc      = '0;
      ref_mem  = mem;
    end else monitor();
    responder();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[i]           = 1'b1;
    req_write[i]           = w;
    req_size[2*i +: 2]     = s;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*32 +: 32]  = d;
  endtask

  task automatic issue(input int i, input bit w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    set_req(i, w, s, a, d);
    for (int t = 0; t < 100; t++) begin
      step();
      if (acc[i]) break;
    end
    check("accept", 64'(acc[i]), 64'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      step();
      if (queue_count == 0 && !ram_ce) break;
    end
    step();
    step();
    check("idle", 64'(queue_count == 0 && !ram_ce), 64'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n_acc, w0, r0, c0;
    bit bad;
    rst = 1'b1; req_valid = '0; req_write = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; ram_rdy = 1'b0; ram_data_in = '0; acc = '0;
    repeat (3) step();
    check("rst_ce", 64'(ram_ce), 64'd0);
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_addr", ram_addr, 64'd0);
    check("rst_dout", ram_data_out, 64'd0);
    check("rst_resp", resp_valid, 64'd0);
    check("rst_qcount", queue_count, 64'd0);
    check("rst_ready", req_ready, 64'd0);
    rst = 1'b0;

    // Word store: RAM access begins two cycles after acceptance.
    issue(0, 1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF);
    check("ws_ce_early", 64'(ram_ce), 64'd0);
    step();
    check("ws_ce", 64'(ram_ce), 64'd1);
    check("ws_we", 64'(ram_we), 64'd1);
    check("ws_addr", ram_addr, 64'h100);
    check("ws_data", ram_data_out, 64'hDEAD_BEEF);
    wait_idle();
    check("ws_qcount", queue_count, 64'd0);

    // Byte store via read-modify-write, then a half load of the merged lane.
    w0 = writes_seen;
    issue(0, 1'b1, 2'b00, 32'h202, 32'h0000_00AA);
    wait_idle();
    check("rmw_writes", 64'(writes_seen - w0), 64'd1);
    check("rmw_waddr", last_waddr, 64'h200);
    check("rmw_wdata", last_wdata, 64'h11AA_3344);
    r0 = resp_cnt;
    issue(0, 1'b0, 2'b01, 32'h202, 32'h0);
    wait_idle();
    check("hl_resp_cnt", 64'(resp_cnt - r0), 64'd1);
    check("hl_rdata", last_resp, 64'h0000_11AA);

    // Both clients load continuously: grants must alternate.
    grants.delete();
    set_req(0, 1'b0, 2'b10, 32'h0, 32'h0);
    set_req(1, 1'b0, 2'b10, 32'h4, 32'h0);
    for (int t = 0; t < 300 && grants.size() < 8; t++) step();
    req_valid = '0;
    wait_idle();
    check("rr_count", 64'(grants.size() >= 8), 64'd1);
    for (int j = 1; j < 8 && j < grants.size(); j++)
      check("rr_alternate", 64'(grants[j] != grants[j-1]), 64'd1);
    check("rr_scoreboard", 64'(expq.size()), 64'd0);

    // Fill the FIFO behind a stalled access.
    stall = 1'b1;
    n_acc = 0;
    set_req(0, 1'b0, 2'b00, 32'h11, 32'h0);
    for (int t = 0; t < 200 && n_acc < QD + 1; t++) begin
      step();
      if (acc[0]) n_acc++;
    end
    check("fill_accepts", 64'(n_acc), 64'(QD + 1));
    check("fill_qcount", queue_count, 64'(QD));
    check("fill_ready", req_ready, 64'd0);
    bad = 1'b0;
    repeat (3) begin
      step();
      if (acc != '0) bad = 1'b1;
    end
    check("fill_no_accept", 64'(bad), 64'd0);
    stall = 1'b0;
    for (int t = 0; t < 50 && queue_count == 4'(QD); t++) step();
    check("drain_qcount", queue_count, 64'(QD - 1));
    check("drain_ready", req_ready, 64'd1);
    req_valid = '0;
    wait_idle();

    // Reset while a read-modify-write read is outstanding.
    stall = 1'b1;
    issue(1, 1'b1, 2'b00, 32'h204, 32'h0000_0055);
    for (int t = 0; t < 20 && !ram_ce; t++) step();
    check("rmwrd_we", 64'(ram_ce && !ram_we), 64'd1);
    w0 = writes_seen; r0 = resp_cnt;
    rst = 1'b1;
    step();
    check("mid_rst_ce", 64'(ram_ce), 64'd0);
    check("mid_rst_qcount", queue_count, 64'd0);
    check("mid_rst_resp", resp_valid, 64'd0);
    rst = 1'b0;
    stall = 1'b0;
    c0 = ce_cycles;
    repeat (20) step();
    check("mid_rst_nowrite", 64'(writes_seen - w0), 64'd0);
    check("mid_rst_noresp", 64'(resp_cnt - r0), 64'd0);
    check("mid_rst_noce", 64'(ce_cycles - c0), 64'd0);

    // Half store to an odd address uses the low half lane of the word.
    issue(0, 1'b1, 2'b01, 32'h301, 32'h0000_BEEF);
    wait_idle();
    check("odd_half_waddr", last_waddr, 64'h300);
    check("odd_half_wdata", last_wdata, 64'h0000_BEEF);

    // Randomized traffic from all clients with random RAM latency.
    rand_en = 1'b1;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'(($urandom & 1)), 2'($urandom_range(0, 3)),
                    32'($urandom_range(0, 31)), $urandom);
          else req_valid[i] = 1'b0;
        end
      end
      step();
    end
    req_valid = '0;
    wait_idle();
    rand_en = 1'b0;
    check("final_scoreboard", 64'(expq.size()), 64'd0);
    n_acc = 0;
    foreach (ref_mem[k]) if (rd_mem(k) !== ref_mem[k]) n_acc++;
    check("final_memory", 64'(n_acc), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
